// File: rtl/cmd_dispatch.sv
// ============================================================================
// cmd_dispatch : decodes commands from the serial shift register, drives the
//                register-bank handshake and fast-command pulses (TMR state)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module cmd_dispatch #(
    parameter int         ACK_TIMEOUT = 15,
    parameter logic [4:0] BCAST_ID    = 5'h1F
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [4:0]  chip_id,
    input  logic [56:0] commandReg,
    input  logic        commandPending,
    input  logic [5:0]  count,
    output logic        reg_req,
    output logic        reg_we,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        trig_pulse,
    output logic        soft_rst_pulse,
    output logic        bcr_pulse,
    output logic        busy,
    output logic [2:0]  err_status,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_PULSE  = 2'd2,
        S_REQ    = 2'd3
    } state_t;

    // Every flop lives in this record so the whole context is triplicated and voted uniformly.
    typedef struct packed {
        state_t       state;
        logic [3:0]   tmo;
        logic [56:0]  shadow;
        logic [5:0]   cnt;
        logic [2:0]   err;
        logic [31:0]  rd_data;
        logic         pend;
        logic         req;
        logic         we;
        logic [7:0]   addr;
        logic [31:0]  wdata;
        logic         rd_valid;
        logic         trig;
        logic         srst;
        logic         bcr;
    } ctx_t;

    localparam logic [3:0] c_TMO_LAST = 4'(ACK_TIMEOUT - 1);
    localparam logic [5:0] c_LONG_LEN = 6'd57;
    localparam logic [3:0] c_SHORT_HDR = 4'b1010;
    localparam logic [3:0] c_TYPE_WR  = 4'b0110;
    localparam logic [3:0] c_TYPE_RD  = 4'b0111;

    ctx_t       ctx_q [3];
    ctx_t       v;
    ctx_t       ctx_d;
    logic       cmd_end;
    logic [2:0] err_set;
    logic       id_ok;
    logic [3:0] ltype;

    assign v = ctx_t'((ctx_q[0] & ctx_q[1]) | (ctx_q[1] & ctx_q[2]) | (ctx_q[0] & ctx_q[2]));

    assign cmd_end = v.pend & ~commandPending;
    assign ltype   = v.shadow[56:53];
    assign id_ok   = (v.shadow[52:48] == chip_id) || (v.shadow[52:48] == BCAST_ID);

    always_comb begin
        ctx_d          = v;
        err_set        = 3'b000;
        ctx_d.rd_valid = 1'b0;
        ctx_d.trig     = 1'b0;
        ctx_d.srst     = 1'b0;
        ctx_d.bcr      = 1'b0;
        ctx_d.pend     = commandPending;
        if (commandPending) begin
            ctx_d.shadow = commandReg;
            ctx_d.cnt    = count;
        end

        case (v.state)
            S_IDLE: begin
                if (cmd_end) ctx_d.state = S_DECODE;
            end
            S_DECODE: begin
                ctx_d.state = S_IDLE;
                if (v.cnt == c_LONG_LEN) begin
                    if (ltype != c_TYPE_WR && ltype != c_TYPE_RD) begin
                        err_set[0] = 1'b1;
                    end else if (id_ok && !(ltype == c_TYPE_RD && v.shadow[52:48] == BCAST_ID)) begin
                        ctx_d.state = S_REQ;
                        ctx_d.req   = 1'b1;
                        ctx_d.we    = (ltype == c_TYPE_WR);
                        ctx_d.addr  = v.shadow[47:40];
                        ctx_d.wdata = v.shadow[39:8];
                        ctx_d.tmo   = 4'd0;
                    end
                end else if (v.shadow[7:4] != c_SHORT_HDR) begin
                    err_set[0] = 1'b1;
                end else begin
                    case (v.shadow[3:0])
                        4'b0001: begin ctx_d.trig = 1'b1; ctx_d.state = S_PULSE; end
                        4'b0010: begin ctx_d.srst = 1'b1; ctx_d.state = S_PULSE; end
                        4'b0100: begin ctx_d.bcr  = 1'b1; ctx_d.state = S_PULSE; end
                        default: err_set[0] = 1'b1;
                    endcase
                end
            end
            S_PULSE: begin
                ctx_d.state = S_IDLE;
            end
            S_REQ: begin
                if (reg_ack) begin
                    ctx_d.req   = 1'b0;
                    ctx_d.state = S_IDLE;
                    if (!v.we) begin
                        ctx_d.rd_data  = reg_rdata;
                        ctx_d.rd_valid = 1'b1;
                    end
                end else if (v.tmo == c_TMO_LAST) begin
                    ctx_d.req   = 1'b0;
                    ctx_d.state = S_IDLE;
                    err_set[1]  = 1'b1;
                end else begin
                    ctx_d.tmo = v.tmo + 4'd1;
                end
            end
            default: ctx_d.state = S_IDLE;
        endcase

        // A command finishing while busy is dropped; the running operation is untouched.
        if (cmd_end && v.state != S_IDLE) err_set[2] = 1'b1;

        ctx_d.err = (v.err & ~{3{err_clr}}) | err_set;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 3; i++) ctx_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) ctx_q[i] <= ctx_d;
        end
    end

    assign reg_req        = v.req;
    assign reg_we         = v.we;
    assign reg_addr       = v.addr;
    assign reg_wdata      = v.wdata;
    assign rd_valid       = v.rd_valid;
    assign rd_data        = v.rd_data;
    assign trig_pulse     = v.trig;
    assign soft_rst_pulse = v.srst;
    assign bcr_pulse      = v.bcr;
    assign busy           = (v.state != S_IDLE);
    assign err_status     = v.err;

endmodule

`default_nettype wire

// File: tb/tb_cmd_dispatch.sv
// ============================================================================
// tb_cmd_dispatch : directed self-checking bench for cmd_dispatch
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rstb;
    logic [4:0]  chip_id;
    logic [56:0] commandReg;
    logic        commandPending;
    logic [5:0]  count;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        trig_pulse;
    logic        soft_rst_pulse;
    logic        bcr_pulse;
    logic        busy;
    logic [2:0]  err_status;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    cmd_dispatch dut (
        .clk(clk), .rstb(rstb), .chip_id(chip_id), .commandReg(commandReg),
        .commandPending(commandPending), .count(count), .reg_req(reg_req),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .rd_valid(rd_valid),
        .rd_data(rd_data), .trig_pulse(trig_pulse), .soft_rst_pulse(soft_rst_pulse),
        .bcr_pulse(bcr_pulse), .busy(busy), .err_status(err_status), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves commandPending low right after an edge, i.e. the first cycle of command end.
    task automatic send(input logic [56:0] val, input logic [5:0] n);
        commandPending = 1'b1;
        commandReg     = val;
        count          = n;
        repeat (3) step();
        commandPending = 1'b0;
    endtask

    function automatic logic [56:0] lcmd(input logic [3:0] t, input logic [4:0] id,
                                         input logic [7:0] a, input logic [31:0] d);
        return {t, id, a, d, 8'h5A};
    endfunction

    function automatic logic [56:0] scmd(input logic [7:0] b);
        return {49'h0, b};
    endfunction

    initial begin
        rstb = 1'b0; chip_id = 5'd3; commandReg = '0; commandPending = 1'b0;
        count = '0; reg_ack = 1'b0; reg_rdata = '0; err_clr = 1'b0;
        repeat (2) step();
        chk("rst_req", {31'h0, reg_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_err", {29'h0, err_status}, 32'h0);
        rstb = 1'b1;
        step();

        // short trigger: pulse exactly at N+2
        send(scmd(8'hA1), 6'd8);
        step();
        chk("trig_n1", {31'h0, trig_pulse}, 32'h0);
        chk("trig_busy_n1", {31'h0, busy}, 32'h1);
        step();
        chk("trig_n2", {31'h0, trig_pulse}, 32'h1);
        step();
        chk("trig_n3", {31'h0, trig_pulse}, 32'h0);
        chk("trig_idle", {31'h0, busy}, 32'h0);
        chk("trig_err", {29'h0, err_status}, 32'h0);

        send(scmd(8'hA2), 6'd8);
        step(); step();
        chk("srst_pulse", {29'h0, trig_pulse, soft_rst_pulse, bcr_pulse}, 32'h2);
        send(scmd(8'hA4), 6'd8);
        step(); step();
        chk("bcr_pulse", {29'h0, trig_pulse, soft_rst_pulse, bcr_pulse}, 32'h1);
        step();

        // long write, ack in the fifth request cycle
        send(lcmd(4'b0110, 5'd3, 8'h2A, 32'hDEADBEEF), 6'd57);
        step(); step();
        chk("wr_we", {31'h0, reg_we}, 32'h1);
        chk("wr_addr", {24'h0, reg_addr}, 32'h2A);
        chk("wr_data", reg_wdata, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            chk("wr_req_hi", {31'h0, reg_req}, 32'h1);
            if (i == 4) reg_ack = 1'b1;
            step();
            reg_ack = 1'b0;
        end
        chk("wr_req_lo", {31'h0, reg_req}, 32'h0);
        chk("wr_no_rdv", {31'h0, rd_valid}, 32'h0);
        step();

        // long read
        send(lcmd(4'b0111, 5'd3, 8'h05, 32'h0), 6'd57);
        step(); step();
        chk("rd_req", {30'h0, reg_req, reg_we}, 32'h2);
        chk("rd_addr", {24'h0, reg_addr}, 32'h05);
        reg_ack = 1'b1; reg_rdata = 32'h12345678;
        step();
        reg_ack = 1'b0; reg_rdata = 32'h0;
        chk("rd_valid", {31'h0, rd_valid}, 32'h1);
        chk("rd_data", rd_data, 32'h12345678);
        chk("rd_req_lo", {31'h0, reg_req}, 32'h0);
        step();
        chk("rd_valid_lo", {31'h0, rd_valid}, 32'h0);
        chk("rd_data_hold", rd_data, 32'h12345678);

        // broadcast read is dropped silently
        send(lcmd(4'b0111, 5'h1F, 8'h05, 32'h0), 6'd57);
        step(); step();
        chk("bcrd_req", {31'h0, reg_req}, 32'h0);
        chk("bcrd_busy", {31'h0, busy}, 32'h0);
        chk("bcrd_err", {29'h0, err_status}, 32'h0);

        // broadcast write executes
        send(lcmd(4'b0110, 5'h1F, 8'h11, 32'hCAFEF00D), 6'd57);
        step(); step();
        chk("bcwr_req", {31'h0, reg_req}, 32'h1);
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        step();

        // write with no ack: 15 request cycles then timeout
        send(lcmd(4'b0110, 5'd3, 8'h33, 32'h0000_0001), 6'd57);
        step(); step();
        for (int i = 0; i < 15; i++) begin
            chk("tmo_req_hi", {31'h0, reg_req}, 32'h1);
            step();
        end
        chk("tmo_req_lo", {31'h0, reg_req}, 32'h0);
        chk("tmo_err", {29'h0, err_status}, 32'h2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", {29'h0, err_status}, 32'h0);

        // foreign id: dropped, no error
        send(lcmd(4'b0110, 5'd7, 8'h2A, 32'h0), 6'd57);
        step(); step();
        chk("fid_req", {31'h0, reg_req}, 32'h0);
        chk("fid_err", {29'h0, err_status}, 32'h0);

        // bad short opcode
        send(scmd(8'hAF), 6'd8);
        step(); step();
        chk("badop_pulses", {29'h0, trig_pulse, soft_rst_pulse, bcr_pulse}, 32'h0);
        chk("badop_err", {29'h0, err_status}, 32'h1);
        // bad long type
        send(lcmd(4'b0011, 5'd3, 8'h2A, 32'h0), 6'd57);
        step(); step();
        chk("badtype_req", {31'h0, reg_req}, 32'h0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // overrun during REQ
        send(lcmd(4'b0110, 5'd3, 8'h2A, 32'h0BADF00D), 6'd57);
        step(); step();
        send(scmd(8'hA1), 6'd8);
        step();
        chk("ovr_err", {29'h0, err_status}, 32'h4);
        chk("ovr_req", {31'h0, reg_req}, 32'h1);
        chk("ovr_addr", {24'h0, reg_addr}, 32'h2A);
        chk("ovr_wdata", reg_wdata, 32'h0BADF00D);
        reg_ack = 1'b1;
        step();
        reg_ack = 1'b0;
        chk("ovr_done", {31'h0, reg_req}, 32'h0);
        step();
        chk("ovr_no_trig", {31'h0, trig_pulse}, 32'h0);
        chk("ovr_idle", {31'h0, busy}, 32'h0);

        // asynchronous reset in the middle of a request
        send(lcmd(4'b0110, 5'd3, 8'h44, 32'h1), 6'd57);
        step(); step();
        chk("prerst_req", {31'h0, reg_req}, 32'h1);
        #2 rstb = 1'b0;
        #1;
        chk("arst_req", {31'h0, reg_req}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_err", {29'h0, err_status}, 32'h0);
        chk("arst_rd_data", rd_data, 32'h0);
        step();
        rstb = 1'b1;
        step();
        chk("post_rst_req", {31'h0, reg_req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
